// File: rtl/isa_defines.sv
// Opcode map, flag indices and operand-format helpers shared by the fetch/decode
// and execute stages.
package isa_defines;

  localparam logic [2:0] OP_OUT  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_LDI  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_ADDI = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_ANDI = 3'b110;
  localparam logic [2:0] OP_SHI  = 3'b111;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;

  typedef struct packed {
    logic       vld;
    logic [2:0] dest;
    logic [7:0] data;
  } wb_t;

  // Ops carrying an 8-bit immediate instead of a second register operand.
  function automatic logic is_imm_op(input logic [2:0] op);
    return (op == OP_LDI) || (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_SHI);
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for the execute stage: result, Z/C and side-effect strobes.
module exec_alu
  import isa_defines::*;
(
  input  logic [2:0] opcode,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] imm,
  output logic [7:0] d,
  output logic       writes_reg,
  output logic       updates_flags,
  output logic       z,
  output logic       c
);

  always_comb begin
    d             = a;
    writes_reg    = 1'b1;
    updates_flags = 1'b1;
    c             = 1'b0;
    case (opcode)
      OP_OUT: begin
        writes_reg    = 1'b0;
        updates_flags = 1'b0;
      end
      OP_ADD:  {c, d} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        d = a - b;
        c = (a < b);
      end
      OP_XOR:  d = a ^ b;
      OP_LDI: begin
        d             = imm;
        updates_flags = 1'b0;
      end
      OP_ADDI: {c, d} = {1'b0, a} + {1'b0, imm};
      OP_ANDI: d = a & imm;
      OP_SHI:  d = imm[7] ? (a >> imm[2:0]) : (a << imm[2:0]);
      default: d = a;
    endcase
    z = (d == 8'h00);
  end

endmodule

// File: rtl/exec_unit.sv
// Two-stage execute/writeback: E reads the register file with a one-deep bypass
// from W and runs the ALU; W commits the result on the following edge.
module exec_unit
  import isa_defines::*;
#(
  parameter logic [7:0] REG_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  input  logic [2:0] opcode,
  input  logic [2:0] src_a,
  input  logic [2:0] src_b,
  input  logic [2:0] dest,
  input  logic [7:0] imm,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       flag_z,
  output logic       flag_c
);

  logic [7:0] rf_q [8];
  wb_t        wb_q, wb_d;
  logic [7:0] out_q, out_d;
  logic       out_vld_q, out_vld_d;
  logic [1:0] flags_q, flags_d;

  logic [7:0] a, b, alu_d;
  logic       alu_wr, alu_fl, alu_z, alu_c;

  // The in-flight W result always beats the regfile, so same-cycle write/read is race-free.
  always_comb begin
    a = (wb_q.vld && wb_q.dest == src_a) ? wb_q.data : rf_q[src_a];
    b = (wb_q.vld && wb_q.dest == src_b) ? wb_q.data : rf_q[src_b];
  end

  exec_alu u_alu (
    .opcode        (opcode),
    .a             (a),
    .b             (b),
    .imm           (imm),
    .d             (alu_d),
    .writes_reg    (alu_wr),
    .updates_flags (alu_fl),
    .z             (alu_z),
    .c             (alu_c)
  );

  always_comb begin
    wb_d = '{vld: 1'b0, dest: wb_q.dest, data: wb_q.data};
    if (op_valid && alu_wr) wb_d = '{vld: 1'b1, dest: dest, data: alu_d};
    out_vld_d = op_valid && (opcode == OP_OUT);
    out_d     = out_vld_d ? a : out_q;
    flags_d   = flags_q;
    if (op_valid && alu_fl) begin
      flags_d[FLAG_Z] = alu_z;
      flags_d[FLAG_C] = alu_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= REG_INIT;
      wb_q      <= '0;
      out_q     <= 8'h00;
      out_vld_q <= 1'b0;
      flags_q   <= 2'b00;
    end else begin
      if (wb_q.vld) rf_q[wb_q.dest] <= wb_q.data;
      wb_q      <= wb_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      flags_q   <= flags_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_vld_q;
  assign flag_z    = flags_q[FLAG_Z];
  assign flag_c    = flags_q[FLAG_C];

endmodule

// File: tb/tb_exec_unit.sv
// Directed plus randomized check of exec_unit against an architectural model that
// applies each op sequentially to an 8-entry register array.
module tb_exec_unit;

  logic       clk = 1'b0;
  logic       rst, op_valid;
  logic [2:0] opcode, src_a, src_b, dest;
  logic [7:0] imm;
  logic [7:0] out;
  logic       out_valid, flag_z, flag_c;

  always #5 clk = ~clk;

  exec_unit #(.REG_INIT(8'h00)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .opcode(opcode),
    .src_a(src_a), .src_b(src_b), .dest(dest), .imm(imm),
    .out(out), .out_valid(out_valid), .flag_z(flag_z), .flag_c(flag_c)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Architectural model: expected outputs after the next active edge.
  logic [7:0] m_reg [8];
  logic [7:0] e_out;
  logic       e_ov, e_z, e_c;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out", out, e_out);
      chk("out_valid", {7'd0, out_valid}, {7'd0, e_ov});
      chk("flag_z", {7'd0, flag_z}, {7'd0, e_z});
      chk("flag_c", {7'd0, flag_c}, {7'd0, e_c});
    end
  end

  task automatic drive(input logic r, input logic v, input logic [2:0] opc,
                       input logic [2:0] sa, input logic [2:0] sb,
                       input logic [2:0] d, input logic [7:0] im);
    int a, b, res;
    bit wr, fl, cy;
    #1;
    rst = r; op_valid = v; opcode = opc; src_a = sa; src_b = sb; dest = d; imm = im;
    if (r) begin
      foreach (m_reg[i]) m_reg[i] = 8'h00;
      e_out = 8'h00; e_ov = 1'b0; e_z = 1'b0; e_c = 1'b0;
    end else begin
      e_ov = 1'b0;
      if (v) begin
        a = m_reg[sa]; b = m_reg[sb]; res = 0; wr = 1; fl = 1; cy = 0;
        case (opc)
          3'd0: begin wr = 0; fl = 0; e_out = 8'(a); e_ov = 1'b1; end
          3'd1: begin res = a + b; cy = (res > 255); end
          3'd3: begin res = a - b + 256; cy = (a < b); end
          3'd5: res = a ^ b;
          3'd2: begin res = im; fl = 0; end
          3'd4: begin res = a + im; cy = (res > 255); end
          3'd6: res = a & im;
          default: res = im[7] ? (a >> im[2:0]) : (a << im[2:0]);
        endcase
        res = res % 256;
        if (wr) m_reg[d] = 8'(res);
        if (fl) begin e_z = (res == 0); e_c = cy; end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic op(input logic [2:0] opc, input logic [2:0] sa, input logic [2:0] sb,
                    input logic [2:0] d, input logic [7:0] im);
    tick();
    drive(1'b0, 1'b1, opc, sa, sb, d, im);
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
  endtask

  initial begin
    drive(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
    chk_en = 1'b1;
    tick();
    chk("rst_out", out, 8'h00);
    chk("rst_ov", {7'd0, out_valid}, 8'h00);
    chk("rst_flags", {6'd0, flag_c, flag_z}, 8'h00);
    drive(1'b1, 1'b1, 3'd2, 3'd0, 3'd0, 3'd1, 8'h33);   // op ignored under reset
    tick(); nop();

    // Bypass chain LDI -> ADD -> OUT
    op(3'd2, 3'd0, 3'd0, 3'd1, 8'h05);
    op(3'd1, 3'd1, 3'd1, 3'd2, 8'h00);
    op(3'd0, 3'd2, 3'd0, 3'd0, 8'h00);
    tick();
    chk("t1_out", out, 8'h0A);
    chk("t1_ov", {7'd0, out_valid}, 8'h01);
    nop(); tick();
    chk("t1_ov_once", {7'd0, out_valid}, 8'h00);
    nop();

    // SUB with borrow
    op(3'd2, 3'd0, 3'd0, 3'd1, 8'h05);
    op(3'd2, 3'd0, 3'd0, 3'd2, 8'h0A);
    op(3'd3, 3'd1, 3'd2, 3'd3, 8'h00);
    op(3'd0, 3'd3, 3'd0, 3'd0, 8'h00);
    tick();
    chk("t2_out", out, 8'hFB);
    chk("t2_z", {7'd0, flag_z}, 8'h00);
    chk("t2_c", {7'd0, flag_c}, 8'h01);
    nop();

    // ADD wrap, then LDI leaves flags alone
    op(3'd2, 3'd0, 3'd0, 3'd4, 8'hFF);
    op(3'd2, 3'd0, 3'd0, 3'd5, 8'h01);
    op(3'd1, 3'd4, 3'd5, 3'd6, 8'h00);
    op(3'd0, 3'd6, 3'd0, 3'd0, 8'h00);
    tick();
    chk("t3_out", out, 8'h00);
    chk("t3_z", {7'd0, flag_z}, 8'h01);
    chk("t3_c", {7'd0, flag_c}, 8'h01);
    drive(1'b0, 1'b1, 3'd2, 3'd0, 3'd0, 3'd6, 8'h10);
    tick();
    chk("t3_ldi_flags", {6'd0, flag_c, flag_z}, 8'h03);
    drive(1'b0, 1'b1, 3'd0, 3'd6, 3'd0, 3'd0, 8'h00);
    tick();
    chk("t3_r6", out, 8'h10);
    nop();

    // Shifts, back-to-back OUTs
    op(3'd2, 3'd0, 3'd0, 3'd1, 8'h81);
    op(3'd7, 3'd1, 3'd0, 3'd2, 8'h01);
    op(3'd7, 3'd1, 3'd0, 3'd3, 8'h81);
    op(3'd0, 3'd2, 3'd0, 3'd0, 8'h00);
    tick();
    chk("t4_shl", out, 8'h02);
    chk("t4_ov0", {7'd0, out_valid}, 8'h01);
    drive(1'b0, 1'b1, 3'd0, 3'd3, 3'd0, 3'd0, 8'h00);
    tick();
    chk("t4_shr", out, 8'h40);
    chk("t4_ov1", {7'd0, out_valid}, 8'h01);
    nop(); tick();
    chk("t4_ov_end", {7'd0, out_valid}, 8'h00);
    nop();

    // Reset while the LDI is in W
    op(3'd2, 3'd0, 3'd0, 3'd4, 8'h77);
    tick();
    drive(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
    tick();
    chk("t5_out", out, 8'h00);
    chk("t5_ov", {7'd0, out_valid}, 8'h00);
    chk("t5_flags", {6'd0, flag_c, flag_z}, 8'h00);
    nop();
    op(3'd0, 3'd4, 3'd0, 3'd0, 8'h00);
    tick();
    chk("t5_r4", out, 8'h00);
    chk("t5_r4_ov", {7'd0, out_valid}, 8'h01);
    nop();

    // Idle gap with random fields
    op(3'd2, 3'd0, 3'd0, 3'd7, 8'h5A);
    op(3'd4, 3'd7, 3'd0, 3'd6, 8'hC0);
    repeat (20) begin tick(); nop(); end
    op(3'd0, 3'd7, 3'd0, 3'd0, 8'h00);
    tick();
    chk("t6_r7", out, 8'h5A);
    chk("t6_c", {7'd0, flag_c}, 8'h01);
    nop();

    // Random traffic
    repeat (600) begin
      tick();
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, 3'($urandom),
            3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
    end
    tick();
    nop();
    tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
Execute/writeback stage directly downstream of the 6-bit-stream instruction fetch/decoder. Consumes one decoded op per op_valid pulse and owns the 8 x 8-bit register file. Runs a 2-stage pipeline: E (read, bypass, ALU) and W (register write). Drives the chip's 8-bit result output and Z/C flags.

Parameters:
REG_INIT, 8'h00, reset value loaded into every register R0..R7.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
op_valid  input  1  one-cycle pulse; fields below coherent when high
opcode  input  3  operation code
src_a  input  3  operand A register index
src_b  input  3  operand B register index (reg-reg ops only)
dest  input  3  destination register index
imm  input  8  immediate (imm ops only)
out  output  8  last OUT value, held between OUT ops
out_valid  output  1  one-cycle pulse when out is updated
flag_z  output  1  zero flag
flag_c  output  1  carry/borrow flag

Behaviour:
- Reset: one clock is synchronous and rst is synchronous, active-high. On a clk edge with rst=1: R0..R7 <= REG_INIT, W-stage valid <= 0 (pending write discarded), out <= 0, out_valid <= 0, flag_z <= 0, flag_c <= 0. op_valid is ignored while rst=1.
- Opcode map (a = R[src_a] after bypass, b = R[src_b] after bypass):
  - 000 OUT: out <= a, out_valid=1. No write, flags unchanged.
  - 001 ADD: d = a+b. C = bit 8 of 9-bit sum.
  - 011 SUB: d = a-b mod 256. C = (a<b) borrow.
  - 101 XOR: d = a^b. C = 0.
  - 010 LDI: d = imm. Flags unchanged.
  - 100 ADDI: d = a+imm. C = carry out.
  - 110 ANDI: d = a&imm. C = 0.
  - 111 SHI: imm[7]=0 -> d = a << imm[2:0]; imm[7]=1 -> d = a >> imm[2:0] (logical). C = 0.
- Z = (d == 0) for every op that updates flags; ops 001, 011, 101, 100, 110, 111 update Z and C.
- All arithmetic is 8-bit wrap.
- Timing, for an op with op_valid high in cycle N:
  - E stage, cycle N: read, bypass, ALU. Edge at end of N registers wb_valid, wb_dest, wb_data, and flags; for OUT it registers out and out_valid.
  - Flags and out are visible in N+1. out_valid is high in N+1 only.
  - W stage, cycle N+1: R[wb_dest] <= wb_data at end of N+1.
  - An immediately following read of that register sees the new value via bypass (N+1) or the regfile (N+2 onward).
- Bypass: if wb_valid and wb_dest == src_a (or src_b), E uses wb_data instead of the regfile. This applies to every register index including R0.
- Back-to-back op_valid on consecutive cycles is fully supported; there is no stall and no ready signal. Throughput is 1 op/cycle.
- op_valid low: E stage idle; wb_valid <= 0; flags, out and registers hold.
- Simultaneous W write and E read of the same register: bypass value wins (no regfile write-then-read race).
- Reset asserted while wb_valid=1: the write is dropped and the register keeps REG_INIT.
- Field values while op_valid=0 are don't-care and must not affect any state.

Decomposition:
- Shared package/include isa_defines:
  - opcode constants OP_OUT, OP_ADD, OP_SUB, OP_XOR, OP_LDI, OP_ADDI, OP_ANDI, OP_SHI
  - helper is_imm_op(opcode) (true for 010/100/110/111), shared with the fetch stage's operand-count decode
  - flag index constants
- One sub-module: exec_alu, purely combinational. Inputs: opcode, a, b, imm. Outputs: d, writes_reg, updates_flags, z, c.
- Register file, bypass and pipeline registers live in exec_unit.

Test Plan:
1. Bypass chain:
   - Stimulus: LDI R1,0x05 (N); ADD R2=R1+R1 (N+1); OUT R2 (N+2).
   - Required: out=0x0A with out_valid=1 in N+3 only.
2. SUB borrow:
   - Stimulus: R1=0x05, R2=0x0A; SUB R3=R1-R2; then OUT R3.
   - Required: flag_z=0, flag_c=1, out=0xFB.
3. ADD wrap:
   - Stimulus: LDI R4,0xFF; LDI R5,0x01; ADD R6=R4+R5.
   - Required: R6=0x00, flag_z=1, flag_c=1. Follow with LDI R6,0x10: flags stay Z=1, C=1.
4. Shifts:
   - Stimulus: R1=0x81; SHI R2=R1,imm 0x01; SHI R3=R1,imm 0x81; OUT R2; OUT R3 on consecutive cycles.
   - Required: out=0x02 then 0x40, out_valid high two consecutive cycles.
5. Reset mid-writeback:
   - Stimulus: LDI R4,0x77 in N; rst=1 at edge ending N+1; after release, OUT R4.
   - Required: out=0x00 (REG_INIT), flags 0, no out_valid during reset.
6. Idle gaps:
   - Stimulus: random field values with op_valid=0 for 20 cycles between ops.
   - Required: registers, flags and out unchanged; out_valid stays 0.
